// File: rtl/qspi_req_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qspi_req_sched : two-port round-robin scheduler driving the        |
// |                  qspi_core CSR bus for single-word flash accesses. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module qspi_req_sched #(
   parameter int unsigned A_WIDTH   = 24,
   parameter logic [7:0]  RD_CMD    = 8'hEB,
   parameter logic [7:0]  WR_CMD    = 8'h32,
   parameter int unsigned CMD_CYC   = 8,
   parameter int unsigned ADDR_CYC  = 6,
   parameter int unsigned DUMMY_CYC = 6,
   parameter int unsigned DATA_CYC  = 8,
   parameter int unsigned SLACK     = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               p0_req_i,
   input  logic [A_WIDTH-1:0] p0_addr_i,
   output logic               p0_gnt_o,
   output logic               p0_ack_o,
   output logic [31:0]        p0_rdata_o,
   input  logic               p1_req_i,
   input  logic               p1_we_i,
   input  logic [A_WIDTH-1:0] p1_addr_i,
   input  logic [31:0]        p1_wdata_i,
   output logic               p1_gnt_o,
   output logic               p1_ack_o,
   output logic [31:0]        p1_rdata_o,
   output logic               busy_o,
   output logic               c_we_o,
   output logic               c_re_o,
   output logic [A_WIDTH-1:0] c_addr_o,
   output logic [31:0]        c_wdata_o,
   input  logic [31:0]        c_rdata_i
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_W_CYC   = 4'd1,
      S_W_ADDR  = 4'd2,
      S_W_WDATA = 4'd3,
      S_W_CMD   = 4'd4,
      S_W_GO    = 4'd5,
      S_WAIT    = 4'd6,
      S_W_STOP  = 4'd7,
      S_RD_REQ  = 4'd8,
      S_RD_CAP  = 4'd9,
      S_DONE    = 4'd10
   } state_t;

   // Counter reload values are N-1 so that WAIT spans exactly N cycles.
   localparam logic [9:0]  c_RD_LOAD = 10'(CMD_CYC + ADDR_CYC + DUMMY_CYC + DATA_CYC + SLACK - 1);
   localparam logic [9:0]  c_WR_LOAD = 10'(CMD_CYC + ADDR_CYC + DATA_CYC + SLACK - 1);
   localparam logic [31:0] c_CYC_RD  = {2'b0, 6'(DUMMY_CYC), 6'(DATA_CYC), 6'd0,
                                        6'(ADDR_CYC), 6'(CMD_CYC)};
   localparam logic [31:0] c_CYC_WR  = {2'b0, 6'd0, 6'd0, 6'(DATA_CYC),
                                        6'(ADDR_CYC), 6'(CMD_CYC)};

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_port;
   logic                 r_we;
   logic                 r_last;
   logic [A_WIDTH-1:0]   r_addr;
   logic [31:0]          r_wdata;
   logic [9:0]           r_cnt;
   logic [31:0]          r_p0_rdata;
   logic [31:0]          r_p1_rdata;
   logic                 w_grant;
   logic                 w_pick1;

   // Port 1 wins when alone, or on a tie when port 0 was served last.
   assign w_pick1 = p1_req_i & (~p0_req_i | ~r_last);
   assign w_grant = (r_state == S_IDLE) & (p0_req_i | p1_req_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:    if (w_grant) w_state_nxt = S_W_CYC;
         S_W_CYC:   w_state_nxt = S_W_ADDR;
         S_W_ADDR:  w_state_nxt = r_we ? S_W_WDATA : S_W_CMD;
         S_W_WDATA: w_state_nxt = S_W_CMD;
         S_W_CMD:   w_state_nxt = S_W_GO;
         S_W_GO:    w_state_nxt = S_WAIT;
         S_WAIT:    if (r_cnt == 10'd0) w_state_nxt = S_W_STOP;
         S_W_STOP:  w_state_nxt = r_we ? S_DONE : S_RD_REQ;
         S_RD_REQ:  w_state_nxt = S_RD_CAP;
         S_RD_CAP:  w_state_nxt = S_DONE;
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_port     <= 1'b0;
         r_we       <= 1'b0;
         r_last     <= 1'b1;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_cnt      <= '0;
         r_p0_rdata <= '0;
         r_p1_rdata <= '0;
      end else begin
         if (w_grant) begin
            r_port  <= w_pick1;
            r_we    <= w_pick1 & p1_we_i;
            r_addr  <= w_pick1 ? p1_addr_i : p0_addr_i;
            r_wdata <= w_pick1 ? p1_wdata_i : 32'd0;
            r_last  <= w_pick1;
         end
         if (r_state == S_W_GO) begin
            r_cnt <= r_we ? c_WR_LOAD : c_RD_LOAD;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 10'd1;
         end
         if (r_state == S_RD_CAP) begin
            if (r_port) r_p1_rdata <= c_rdata_i;
            else        r_p0_rdata <= c_rdata_i;
         end
      end
   end

   // Core bus is fully decoded from state; address/data are zero when idle.
   always_comb begin
      c_we_o    = 1'b0;
      c_re_o    = 1'b0;
      c_addr_o  = '0;
      c_wdata_o = '0;
      unique case (r_state)
         S_W_CYC: begin
            c_we_o    = 1'b1;
            c_wdata_o = r_we ? c_CYC_WR : c_CYC_RD;
         end
         S_W_ADDR: begin
            c_we_o    = 1'b1;
            c_addr_o  = A_WIDTH'(12);
            c_wdata_o = 32'(r_addr);
         end
         S_W_WDATA: begin
            c_we_o    = 1'b1;
            c_addr_o  = A_WIDTH'(4);
            c_wdata_o = r_wdata;
         end
         S_W_CMD: begin
            c_we_o    = 1'b1;
            c_addr_o  = A_WIDTH'(16);
            c_wdata_o = {24'd0, r_we ? WR_CMD : RD_CMD};
         end
         S_W_GO: begin
            c_we_o    = 1'b1;
            c_addr_o  = A_WIDTH'(20);
            c_wdata_o = r_we ? 32'hA : 32'h9;
         end
         S_W_STOP: begin
            c_we_o    = 1'b1;
            c_addr_o  = A_WIDTH'(20);
         end
         S_RD_REQ: begin
            c_re_o    = 1'b1;
            c_addr_o  = A_WIDTH'(8);
         end
         default: ;
      endcase
   end

   // Grants are combinational, so they are masked while reset is held.
   assign p0_gnt_o   = rst_ni & w_grant & ~w_pick1;
   assign p1_gnt_o   = rst_ni & w_grant & w_pick1;
   assign p0_ack_o   = (r_state == S_DONE) & ~r_port;
   assign p1_ack_o   = (r_state == S_DONE) & r_port;
   assign p0_rdata_o = r_p0_rdata;
   assign p1_rdata_o = r_p1_rdata;
   assign busy_o     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_qspi_req_sched.sv
`default_nettype none
// Randomized scoreboard bench for qspi_req_sched: default instance plus a
// minimum-budget instance (all cycle counts 1, no slack).
module tb_qspi_req_sched;

   localparam int CMD = 8, ADR = 6, DUM = 6, DAT = 8, SLK = 4;

   typedef struct {int cyc; logic [23:0] a; logic [31:0] d;} bus_t;
   typedef struct {int cyc; bit port; logic [31:0] rd;} ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic p0_req = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [23:0] p0_addr = '0, p1_addr = '0;
   logic [31:0] p1_wdata = '0;
   logic p0_gnt, p0_ack, p1_gnt, p1_ack, busy, c_we, c_re;
   logic [31:0] p0_rdata, p1_rdata, c_wdata;
   logic [23:0] c_addr;
   logic [31:0] c_rdata = '0, core_val = '0;

   logic m_p0_req = 1'b0;
   logic [23:0] m_p0_addr = '0;
   logic m_p0_gnt, m_p0_ack, m_p1_gnt, m_p1_ack, m_busy, m_c_we, m_c_re;
   logic [31:0] m_p0_rdata, m_p1_rdata, m_c_wdata;
   logic [23:0] m_c_addr;
   logic [31:0] m_c_rdata = '0, m_core_val = '0;

   int cyc = 0;
   int n_vec = 0, n_miss = 0;
   bus_t wq[$], rq[$], ew[$];
   ev_t gq[$], aq[$];
   int busy_cnt = 0, bus_bad = 0;
   bit m_last = 1'b1;
   logic [31:0] exp_rd [2];

   qspi_req_sched u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .p0_req_i(p0_req), .p0_addr_i(p0_addr), .p0_gnt_o(p0_gnt), .p0_ack_o(p0_ack),
      .p0_rdata_o(p0_rdata),
      .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
      .p1_gnt_o(p1_gnt), .p1_ack_o(p1_ack), .p1_rdata_o(p1_rdata),
      .busy_o(busy), .c_we_o(c_we), .c_re_o(c_re), .c_addr_o(c_addr),
      .c_wdata_o(c_wdata), .c_rdata_i(c_rdata)
   );

   qspi_req_sched #(.CMD_CYC(1), .ADDR_CYC(1), .DUMMY_CYC(1), .DATA_CYC(1), .SLACK(0)) u_min (
      .clk_i(clk), .rst_ni(rst_n),
      .p0_req_i(m_p0_req), .p0_addr_i(m_p0_addr), .p0_gnt_o(m_p0_gnt), .p0_ack_o(m_p0_ack),
      .p0_rdata_o(m_p0_rdata),
      .p1_req_i(1'b0), .p1_we_i(1'b0), .p1_addr_i(24'd0), .p1_wdata_i(32'd0),
      .p1_gnt_o(m_p1_gnt), .p1_ack_o(m_p1_ack), .p1_rdata_o(m_p1_rdata),
      .busy_o(m_busy), .c_we_o(m_c_we), .c_re_o(m_c_re), .c_addr_o(m_c_addr),
      .c_wdata_o(m_c_wdata), .c_rdata_i(m_c_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core stand-in: read data appears the cycle after re, noise otherwise.
   always @(posedge clk) begin
      c_rdata   <= c_re   ? core_val   : $urandom;
      m_c_rdata <= m_c_re ? m_core_val : $urandom;
   end

   always @(negedge clk) begin
      if (c_we) wq.push_back('{cyc, c_addr, c_wdata});
      if (c_re) rq.push_back('{cyc, c_addr, c_wdata});
      if ((c_we && c_re) || (!c_we && !c_re && (c_addr != 0 || c_wdata != 0))) bus_bad++;
      if (p0_gnt) gq.push_back('{cyc, 1'b0, 32'd0});
      if (p1_gnt) gq.push_back('{cyc, 1'b1, 32'd0});
      if (p0_ack) aq.push_back('{cyc, 1'b0, p0_rdata});
      if (p1_ack) aq.push_back('{cyc, 1'b1, p1_rdata});
      if (busy) busy_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
      $fatal(1);
   end

   function automatic int budget_n(input bit we);
      return CMD + ADR + DAT + SLK + (we ? 0 : DUM);
   endfunction

   task automatic clear_logs();
      wq.delete(); rq.delete(); gq.delete(); aq.delete();
      busy_cnt = 0; bus_bad = 0;
   endtask

   task automatic wait_acks(input int n, input int budget);
      int k = 0;
      while (aq.size() < n && k < budget) begin
         @(negedge clk); #1; k++;
      end
      n_vec++;
      if (aq.size() < n) begin
         n_miss++;
         $display("FAIL ack_timeout: got %0d acks, required %0d", aq.size(), n);
      end
   endtask

   // Expected core-bus write sequence, built from the register map.
   task automatic build_exp(input bit we, input logic [23:0] a, input logic [31:0] wd);
      logic [31:0] cw;
      ew.delete();
      if (we) cw = CMD + (ADR << 6) + (DAT << 12);
      else    cw = CMD + (ADR << 6) + (DAT << 18) + (DUM << 24);
      ew.push_back('{0, 24'd0, cw});
      ew.push_back('{0, 24'd12, {8'd0, a}});
      if (we) ew.push_back('{0, 24'd4, wd});
      ew.push_back('{0, 24'd16, we ? 32'h32 : 32'hEB});
      ew.push_back('{0, 24'd20, we ? 32'hA : 32'h9});
      ew.push_back('{0, 24'd20, 32'd0});
   endtask

   task automatic test_reset();
      p0_req = 1'b1; p1_req = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if ({p0_gnt, p0_ack, p0_rdata, p1_gnt, p1_ack, p1_rdata, busy, c_we, c_re, c_addr, c_wdata} !== '0) begin
         n_miss++;
         $display("FAIL reset_outputs: gnt=%b%b ack=%b%b busy=%b we=%b re=%b rd0=%h rd1=%h, required all 0",
                  p0_gnt, p1_gnt, p0_ack, p1_ack, busy, c_we, c_re, p0_rdata, p1_rdata);
      end
      p0_req = 1'b0; p1_req = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      m_last = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0;
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic test_txn(input bit port, input bit we, input logic [23:0] addr, input logic [31:0] wd);
      int n, lat, gc, ac;
      bit ok;
      clear_logs();
      core_val = $urandom;
      @(posedge clk); #1;
      if (port) begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
      else      begin p0_req = 1'b1; p0_addr = addr; end
      @(posedge clk); #1;
      p0_req = 1'b0; p1_req = 1'b0;
      p0_addr = $urandom; p1_addr = $urandom; p1_wdata = $urandom; p1_we = 1'($urandom);
      wait_acks(1, 200);
      m_last = port;
      if (!we) exp_rd[port] = core_val;
      build_exp(we, addr, wd);
      n = budget_n(we);
      lat = we ? 7 + n : 8 + n;
      gc = (gq.size() > 0) ? gq[0].cyc : -1000;
      ac = (aq.size() > 0) ? aq[0].cyc : -1000;

      n_vec++;
      if (gq.size() != 1 || gq[0].port != port) begin
         n_miss++;
         $display("FAIL grant: %0d grants (first port %0d), required 1 grant to port %0d",
                  gq.size(), (gq.size() > 0) ? int'(gq[0].port) : -1, port);
      end
      n_vec++;
      if (aq.size() != 1 || aq[0].port != port || ac - gc != lat) begin
         n_miss++;
         $display("FAIL ack: %0d acks, latency %0d, required 1 ack to port %0d at latency %0d",
                  aq.size(), ac - gc, port, lat);
      end
      ok = (wq.size() == ew.size());
      for (int i = 0; ok && i < ew.size(); i++)
         if (wq[i].a !== ew[i].a || wq[i].d !== ew[i].d) ok = 1'b0;
      n_vec++;
      if (!ok) begin
         n_miss++;
         $display("FAIL bus_writes: %0d writes seen (first %h/%h), required %0d (first %h/%h)",
                  wq.size(), (wq.size() > 0) ? wq[0].a : 24'hx, (wq.size() > 0) ? wq[0].d : 32'hx,
                  ew.size(), ew[0].a, ew[0].d);
      end
      n_vec++;
      if (wq.size() >= 2 && wq[wq.size()-1].cyc - wq[wq.size()-2].cyc - 1 != n) begin
         n_miss++;
         $display("FAIL wait_len: %0d cycles, required %0d",
                  wq[wq.size()-1].cyc - wq[wq.size()-2].cyc - 1, n);
      end
      n_vec++;
      if (rq.size() != (we ? 0 : 1) || (!we && rq[0].a !== 24'd8)) begin
         n_miss++;
         $display("FAIL read_fetch: %0d re pulses, required %0d at addr 8", rq.size(), we ? 0 : 1);
      end
      n_vec++;
      if (p0_rdata !== exp_rd[0] || p1_rdata !== exp_rd[1]) begin
         n_miss++;
         $display("FAIL rdata: p0=%h p1=%h, required p0=%h p1=%h", p0_rdata, p1_rdata, exp_rd[0], exp_rd[1]);
      end
      n_vec++;
      if (busy_cnt != lat || bus_bad != 0) begin
         n_miss++;
         $display("FAIL busy_bus: busy %0d cycles, %0d idle-bus faults, required %0d and 0",
                  busy_cnt, bus_bad, lat);
      end
   endtask

   task automatic test_random();
      bit port, we;
      for (int t = 0; t < 24; t++) begin
         port = 1'($urandom);
         we   = port ? 1'($urandom) : 1'b0;
         test_txn(port, we, 24'($urandom), $urandom);
      end
   endtask

   task automatic test_back_to_back();
      bit exp_port;
      bit wr1;
      clear_logs();
      core_val = $urandom;
      wr1 = 1'($urandom);
      @(posedge clk); #1;
      p0_req = 1'b1; p1_req = 1'b1; p1_we = wr1;
      p0_addr = $urandom; p1_addr = $urandom; p1_wdata = $urandom;
      wait_acks(4, 400);
      p0_req = 1'b0; p1_req = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if (gq.size() != 4 || aq.size() != 4) begin
         n_miss++;
         $display("FAIL rr_count: %0d grants %0d acks, required 4 and 4", gq.size(), aq.size());
      end
      for (int i = 0; i < 4 && i < gq.size() && i < aq.size(); i++) begin
         exp_port = ~m_last;
         m_last = exp_port;
         if (exp_port == 1'b0 || !wr1) exp_rd[exp_port] = core_val;
         n_vec++;
         if (gq[i].port != exp_port || aq[i].port != exp_port || aq[i].cyc <= gq[i].cyc ||
             (i < gq.size() - 1 && gq[i+1].cyc <= aq[i].cyc)) begin
            n_miss++;
            $display("FAIL rr_order[%0d]: gnt port %0d ack port %0d, required port %0d with ack before next gnt",
                     i, gq[i].port, aq[i].port, exp_port);
         end
      end
      n_vec++;
      if (p0_rdata !== exp_rd[0] || p1_rdata !== exp_rd[1]) begin
         n_miss++;
         $display("FAIL rr_rdata: p0=%h p1=%h, required p0=%h p1=%h", p0_rdata, p1_rdata, exp_rd[0], exp_rd[1]);
      end
   endtask

   task automatic test_req_while_busy();
      clear_logs();
      core_val = $urandom;
      @(posedge clk); #1;
      p0_req = 1'b1; p0_addr = $urandom;
      @(posedge clk); #1;
      p0_req = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = $urandom; p1_wdata = $urandom;
      for (int k = 0; k < 100 && gq.size() < 2; k++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      p1_req = 1'b0;
      wait_acks(2, 200);
      exp_rd[0] = core_val;
      m_last = 1'b1;
      n_vec++;
      if (gq.size() != 2 || aq.size() < 1 || gq[1].port != 1'b1 || gq[1].cyc != aq[0].cyc + 1) begin
         n_miss++;
         $display("FAIL busy_ignore: %0d grants, p1 gnt at %0d, required p1 gnt at %0d",
                  gq.size(), (gq.size() > 1) ? gq[1].cyc : -1, (aq.size() > 0) ? aq[0].cyc + 1 : -1);
      end
      n_vec++;
      if (aq.size() != 2 || aq[1].port != 1'b1 || aq[1].cyc - gq[1].cyc != 7 + budget_n(1'b1)) begin
         n_miss++;
         $display("FAIL busy_p1_ack: %0d acks, latency %0d, required p1 ack at latency %0d",
                  aq.size(), (aq.size() > 1 && gq.size() > 1) ? aq[1].cyc - gq[1].cyc : -1, 7 + budget_n(1'b1));
      end
   endtask

   task automatic test_reset_mid_wait();
      clear_logs();
      @(posedge clk); #1;
      p0_req = 1'b1; p0_addr = $urandom;
      @(posedge clk); #1;
      p0_req = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({p0_gnt, p0_ack, p0_rdata, p1_gnt, p1_ack, p1_rdata, busy, c_we, c_re, c_addr, c_wdata} !== '0) begin
         n_miss++;
         $display("FAIL midreset_outputs: busy=%b we=%b re=%b rd0=%h rd1=%h, required all 0",
                  busy, c_we, c_re, p0_rdata, p1_rdata);
      end
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      m_last = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0;
      repeat (40) @(negedge clk);
      #1;
      n_vec++;
      if (aq.size() != 0 || busy !== 1'b0) begin
         n_miss++;
         $display("FAIL midreset_abort: %0d acks busy=%b, required 0 acks busy=0", aq.size(), busy);
      end
      test_txn(1'b0, 1'b0, 24'($urandom), 32'd0);
   endtask

   task automatic test_min_params();
      int g = -1, a = -1, go = -1, stop = -1, first_cyc = -1;
      logic [31:0] cw = 'x, rd = 'x;
      m_core_val = $urandom;
      @(posedge clk); #1;
      m_p0_req = 1'b1; m_p0_addr = $urandom;
      @(negedge clk); #1;
      if (m_p0_gnt) g = cyc;
      @(posedge clk); #1;
      m_p0_req = 1'b0;
      for (int k = 0; k < 100 && a < 0; k++) begin
         @(negedge clk); #1;
         if (m_c_we && first_cyc < 0) begin first_cyc = cyc; cw = m_c_wdata; end
         if (m_c_we && m_c_addr == 24'd20 && m_c_wdata == 32'h9) go = cyc;
         if (m_c_we && m_c_addr == 24'd20 && m_c_wdata == 32'h0) stop = cyc;
         if (m_p0_ack) begin a = cyc; rd = m_p0_rdata; end
      end
      n_vec++;
      if (g < 0 || a - g != 12) begin
         n_miss++;
         $display("FAIL min_latency: gnt at %0d ack at %0d, required ack 12 cycles after gnt", g, a);
      end
      n_vec++;
      if (stop - go - 1 != 4) begin
         n_miss++;
         $display("FAIL min_wait_len: %0d cycles, required 4", stop - go - 1);
      end
      n_vec++;
      if (cw !== 32'h0104_0041 || rd !== m_core_val) begin
         n_miss++;
         $display("FAIL min_data: cycle word %h rdata %h, required 01040041 and %h", cw, rd, m_core_val);
      end
   endtask

   initial begin
      test_reset();
      test_txn(1'b0, 1'b0, 24'h001000, 32'd0);
      test_txn(1'b1, 1'b1, 24'h00ABCD, 32'h12345678);
      test_random();
      test_back_to_back();
      test_req_while_busy();
      test_reset_mid_wait();
      test_min_params();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
